// File: rtl/mem_arbiter_pkg.sv
// Encodings and widths shared by the instruction/data memory arbiter and its bench.
package mem_arbiter_pkg;

  localparam int ADDR_W  = 6;
  localparam int BLOCK_W = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one block memory port between an instruction cache (read only)
// and a data cache (read/write), round-robin when both ask at once.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | no owner; any request is granted on the next edge
// ST_GRANT | memory strobe held from registers until busy has come and gone
// ST_DONE  | one-cycle completion; owner's busywait drops here
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic               I_READ,
  input  logic [ADDR_W-1:0]  I_ADDRESS,
  output logic [BLOCK_W-1:0] I_READDATA,
  output logic               I_BUSYWAIT,
  input  logic               D_READ,
  input  logic               D_WRITE,
  input  logic [ADDR_W-1:0]  D_ADDRESS,
  input  logic [BLOCK_W-1:0] D_WRITEDATA,
  output logic [BLOCK_W-1:0] D_READDATA,
  output logic               D_BUSYWAIT,
  output logic               MEM_READ,
  output logic               MEM_WRITE,
  output logic [ADDR_W-1:0]  MEM_ADDRESS,
  output logic [BLOCK_W-1:0] MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0] MEM_READDATA,
  input  logic               MEM_BUSYWAIT
);

  logic [1:0]         r_state;
  logic               r_owner;
  logic               r_last_owner;
  logic               r_seen_busy;
  logic               r_mem_read;
  logic               r_mem_write;
  logic [ADDR_W-1:0]  r_mem_address;
  logic [BLOCK_W-1:0] r_mem_writedata;
  logic [BLOCK_W-1:0] r_i_readdata;
  logic [BLOCK_W-1:0] r_d_readdata;

  logic w_i_req;
  logic w_d_req;
  logic w_next_owner;
  logic w_complete;

  assign w_i_req = I_READ;
  assign w_d_req = D_READ | D_WRITE;
  // Contention goes to whoever did not own the last completed transaction.
  assign w_next_owner = (w_i_req & w_d_req) ? ~r_last_owner : w_d_req;
  assign w_complete   = r_seen_busy & ~MEM_BUSYWAIT;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state         <= ST_IDLE;
      r_owner         <= OWN_I;
      r_last_owner    <= OWN_I;
      r_seen_busy     <= 1'b0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_address   <= '0;
      r_mem_writedata <= '0;
      r_i_readdata    <= '0;
      r_d_readdata    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_i_req | w_d_req) begin
            r_state     <= ST_GRANT;
            r_owner     <= w_next_owner;
            r_seen_busy <= 1'b0;
            if (w_next_owner == OWN_D) begin
              r_mem_address   <= D_ADDRESS;
              r_mem_writedata <= D_WRITEDATA;
              r_mem_write     <= D_WRITE;
              r_mem_read      <= ~D_WRITE;
            end else begin
              r_mem_address <= I_ADDRESS;
              r_mem_write   <= 1'b0;
              r_mem_read    <= 1'b1;
            end
          end
        end
        ST_GRANT: begin
          if (MEM_BUSYWAIT) begin
            r_seen_busy <= 1'b1;
          end
          if (w_complete) begin
            r_state     <= ST_DONE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (r_mem_read) begin
              if (r_owner == OWN_D) begin
                r_d_readdata <= MEM_READDATA;
              end else begin
                r_i_readdata <= MEM_READDATA;
              end
            end
          end
        end
        ST_DONE: begin
          r_state      <= ST_IDLE;
          r_last_owner <= r_owner;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign I_BUSYWAIT    = w_i_req & ~((r_state == ST_DONE) & (r_owner == OWN_I));
  assign D_BUSYWAIT    = w_d_req & ~((r_state == ST_DONE) & (r_owner == OWN_D));
  assign I_READDATA    = r_i_readdata;
  assign D_READDATA    = r_d_readdata;
  assign MEM_READ      = r_mem_read;
  assign MEM_WRITE     = r_mem_write;
  assign MEM_ADDRESS   = r_mem_address;
  assign MEM_WRITEDATA = r_mem_writedata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, corner sequences and
// random two-requester traffic against a memory/fairness reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        I_READ = 1'b0;
  logic [5:0]  I_ADDRESS = '0;
  logic [31:0] I_READDATA;
  logic        I_BUSYWAIT;
  logic        D_READ = 1'b0;
  logic        D_WRITE = 1'b0;
  logic [5:0]  D_ADDRESS = '0;
  logic [31:0] D_WRITEDATA = '0;
  logic [31:0] D_READDATA;
  logic        D_BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  mem_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input logic [5:0] a);
    return (a == 6'h05) ? 32'hDEADBEEF : {8'hC0, 2'b00, a, 16'h1234};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Main memory: busy rises with the strobe and stays for mem_n cycles.
  logic [31:0] tb_mem [64];
  logic [63:0] tb_wr = '0;
  logic        mem_hang = 1'b0;
  int          mem_fixed_n = 0;
  int          mem_n = 1;
  int          mem_cnt = 0;
  logic        mem_done = 1'b0;

  assign MEM_BUSYWAIT = !mem_hang && (MEM_READ || MEM_WRITE) && !mem_done;
  assign MEM_READDATA = tb_wr[MEM_ADDRESS] ? tb_mem[MEM_ADDRESS] : pat(MEM_ADDRESS);

  always @(posedge CLK) begin
    if (!(MEM_READ || MEM_WRITE)) begin
      mem_cnt  <= 0;
      mem_done <= 1'b0;
      mem_n    <= (mem_fixed_n > 0) ? mem_fixed_n : int'($urandom_range(1, 4));
    end else if (!mem_done && !mem_hang) begin
      mem_cnt <= mem_cnt + 1;
      if (mem_cnt + 1 >= mem_n) begin
        mem_done <= 1'b1;
        if (MEM_WRITE) begin
          tb_mem[MEM_ADDRESS] <= MEM_WRITEDATA;
          tb_wr[MEM_ADDRESS]  <= 1'b1;
        end
      end
    end
  end

  // Reference state for the random phase.
  logic [31:0] model_mem [64];
  logic [63:0] model_wr = '0;
  int req_since [2] = '{-1, -1};
  int last_owner = -1;
  int last_done = -1000;

  function automatic logic [31:0] model_rd(input logic [5:0] a);
    return model_wr[a] ? model_mem[a] : pat(a);
  endfunction

  // A requester may not win twice running while the other waited through the gap.
  task automatic note_done(input int who);
    int other;
    other = 1 - who;
    if (last_owner == who && req_since[other] >= 0)
      check("rr_fair", 32'(req_since[other] <= last_done + 1), 32'd0);
    last_owner = who;
    last_done  = cyc;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    I_READ = 1'b0; D_READ = 1'b0; D_WRITE = 1'b0;
    I_ADDRESS = '0; D_ADDRESS = '0; D_WRITEDATA = '0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
  endtask

  task automatic run_solo(input logic is_i, input logic rd, input logic wr, input logic [5:0] addr,
                          input logic [31:0] wd, input int n,
                          output int mr, output int mw, output int lat, output logic to);
    int t0;
    mem_fixed_n = n;
    mr = 0; mw = 0; lat = 0; to = 1'b1;
    @(posedge CLK); #1;
    if (is_i) begin
      I_READ = 1'b1; I_ADDRESS = addr;
    end else begin
      D_READ = rd; D_WRITE = wr; D_ADDRESS = addr; D_WRITEDATA = wd;
    end
    t0 = cyc;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (MEM_READ) mr++;
      if (MEM_WRITE) mw++;
      if (!(is_i ? I_BUSYWAIT : D_BUSYWAIT)) begin
        lat = cyc - t0 + 1;  // request cycle and first unstalled cycle both counted
        to = 1'b0;
        break;
      end
    end
    @(posedge CLK); #1;
    I_READ = 1'b0; D_READ = 1'b0; D_WRITE = 1'b0;
  endtask

  task automatic proc_d();
    logic [31:0] d_exp;
    logic [5:0]  a;
    logic [31:0] wd;
    int gap, op;
    logic got;
    d_exp = '0;
    @(posedge CLK); #1;
    for (int k = 0; k < 25; k++) begin
      gap = int'($urandom_range(0, 2));
      op  = int'($urandom_range(0, 2));
      a   = 6'h20 + 6'($urandom_range(0, 7));
      wd  = $urandom;
      repeat (gap) begin @(posedge CLK); #1; end
      D_READ = (op != 1); D_WRITE = (op != 0); D_ADDRESS = a; D_WRITEDATA = wd;
      req_since[1] = cyc;
      got = 1'b0;
      for (int w = 0; w < 300; w++) begin
        @(negedge CLK);
        if (!D_BUSYWAIT) begin got = 1'b1; break; end
      end
      check("rnd_d_complete", 32'(got), 32'd1);
      if (got) begin
        if (op == 0) begin
          d_exp = model_rd(a);
          check("rnd_d_rdata", D_READDATA, d_exp);
        end else begin
          check("rnd_d_rdata_hold", D_READDATA, d_exp);
          model_mem[a] = wd;
          model_wr[a]  = 1'b1;
        end
        note_done(1);
      end
      req_since[1] = -1;
      @(posedge CLK); #1;
      D_READ = 1'b0; D_WRITE = 1'b0;
    end
  endtask

  task automatic proc_i();
    logic [5:0] a;
    int gap;
    logic got;
    @(posedge CLK); #1;
    for (int k = 0; k < 25; k++) begin
      gap = int'($urandom_range(0, 2));
      a   = 6'h20 + 6'($urandom_range(0, 7));
      repeat (gap) begin @(posedge CLK); #1; end
      I_READ = 1'b1; I_ADDRESS = a;
      req_since[0] = cyc;
      got = 1'b0;
      for (int w = 0; w < 300; w++) begin
        @(negedge CLK);
        if (!I_BUSYWAIT) begin got = 1'b1; break; end
      end
      check("rnd_i_complete", 32'(got), 32'd1);
      if (got) begin
        check("rnd_i_rdata", I_READDATA, model_rd(a));
        note_done(0);
      end
      req_since[0] = -1;
      @(posedge CLK); #1;
      I_READ = 1'b0;
    end
  endtask

  typedef struct {
    logic        is_i;
    logic        rd;
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] wd;
    int          n;
    int          exp_mr;
    int          exp_mw;
    int          exp_lat;
    logic [31:0] exp_i_rd;
    logic [31:0] exp_d_rd;
  } vec_t;

  vec_t vt [6];

  initial begin
    int mr, mw, lat, cnt_a, cnt_b;
    logic to, ok;
    logic got_owner;

    vt[0] = '{1'b0, 1'b1, 1'b0, 6'h05, 32'h0,        5, 6, 0, 8, 32'h0,        32'hDEADBEEF};
    vt[1] = '{1'b1, 1'b1, 1'b0, 6'h03, 32'h0,        2, 3, 0, 5, pat(6'h03),   32'hDEADBEEF};
    vt[2] = '{1'b0, 1'b0, 1'b1, 6'h0A, 32'h12345678, 3, 0, 4, 6, pat(6'h03),   32'hDEADBEEF};
    vt[3] = '{1'b0, 1'b1, 1'b1, 6'h11, 32'hCAFEF00D, 1, 0, 2, 4, pat(6'h03),   32'hDEADBEEF};
    vt[4] = '{1'b0, 1'b1, 1'b0, 6'h11, 32'h0,        4, 5, 0, 7, pat(6'h03),   32'hCAFEF00D};
    vt[5] = '{1'b1, 1'b1, 1'b0, 6'h0A, 32'h0,        1, 2, 0, 4, 32'h12345678, 32'hCAFEF00D};

    // Reset state, with a data request already up.
    #1 RESET = 1'b0;
    D_READ = 1'b1;
    #12;
    check("rst_mem_read", 32'(MEM_READ), 32'd0);
    check("rst_mem_write", 32'(MEM_WRITE), 32'd0);
    check("rst_mem_addr", 32'(MEM_ADDRESS), 32'd0);
    check("rst_i_rdata", I_READDATA, 32'd0);
    check("rst_d_rdata", D_READDATA, 32'd0);
    check("rst_d_busy_stalled", 32'(D_BUSYWAIT), 32'd1);
    check("rst_i_busy_idle", 32'(I_BUSYWAIT), 32'd0);
    do_reset();

    // Contention right after reset: data goes first, instruction waits.
    mem_fixed_n = 2;
    @(posedge CLK); #1;
    I_READ = 1'b1; I_ADDRESS = 6'h07;
    D_WRITE = 1'b1; D_ADDRESS = 6'h0A; D_WRITEDATA = 32'h12345678;
    @(negedge CLK);
    check("ct_i_busy_same_cycle", 32'(I_BUSYWAIT), 32'd1);
    check("ct_d_busy_same_cycle", 32'(D_BUSYWAIT), 32'd1);
    ok = 1'b0; cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (!I_BUSYWAIT) cnt_a++;
      if (MEM_READ) cnt_b++;
      if (!D_BUSYWAIT) begin ok = 1'b1; break; end
    end
    check("ct_d_done", 32'(ok), 32'd1);
    check("ct_i_stalled", 32'(cnt_a), 32'd0);
    check("ct_d_no_memread", 32'(cnt_b), 32'd0);
    check("ct_mem_written", tb_mem[6'h0A], 32'h12345678);
    @(posedge CLK); #1 D_WRITE = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (!I_BUSYWAIT) begin ok = 1'b1; break; end
    end
    check("ct_i_done", 32'(ok), 32'd1);
    check("ct_i_rdata", I_READDATA, pat(6'h07));
    @(posedge CLK); #1 I_READ = 1'b0;

    // Single-requester transactions from the table.
    do_reset();
    for (int v = 0; v < 6; v++) begin
      run_solo(vt[v].is_i, vt[v].rd, vt[v].wr, vt[v].addr, vt[v].wd, vt[v].n, mr, mw, lat, to);
      check($sformatf("tbl%0d_timeout", v), 32'(to), 32'd0);
      check($sformatf("tbl%0d_memread_cycles", v), 32'(mr), 32'(vt[v].exp_mr));
      check($sformatf("tbl%0d_memwrite_cycles", v), 32'(mw), 32'(vt[v].exp_mw));
      check($sformatf("tbl%0d_latency", v), 32'(lat), 32'(vt[v].exp_lat));
      check($sformatf("tbl%0d_i_rdata", v), I_READDATA, vt[v].exp_i_rd);
      check($sformatf("tbl%0d_d_rdata", v), D_READDATA, vt[v].exp_d_rd);
    end

    // Both requesters held active: grants alternate D, I, D, I.
    do_reset();
    mem_fixed_n = 1;
    @(posedge CLK); #1;
    I_READ = 1'b1; I_ADDRESS = 6'h01; D_READ = 1'b1; D_ADDRESS = 6'h02;
    for (int t = 0; t < 4; t++) begin
      ok = 1'b0; got_owner = OWN_I;
      for (int k = 0; k < 50; k++) begin
        @(negedge CLK);
        if (!I_BUSYWAIT || !D_BUSYWAIT) begin
          ok = 1'b1;
          got_owner = !D_BUSYWAIT ? OWN_D : OWN_I;
          break;
        end
      end
      check($sformatf("alt%0d_done", t), 32'(ok), 32'd1);
      check($sformatf("alt%0d_owner", t), 32'(got_owner), (t % 2 == 0) ? 32'(OWN_D) : 32'(OWN_I));
    end
    @(posedge CLK); #1;
    I_READ = 1'b0; D_READ = 1'b0;

    // Reset pulsed in the middle of a grant.
    mem_fixed_n = 5;
    @(posedge CLK); #1;
    D_READ = 1'b1; D_ADDRESS = 6'h05;
    repeat (3) @(negedge CLK);
    check("mid_pre_memread", 32'(MEM_READ), 32'd1);
    #2 RESET = 1'b0;
    #1;
    check("mid_memread_async", 32'(MEM_READ), 32'd0);
    check("mid_state_idle", 32'(dut.r_state), 32'(ST_IDLE));
    check("mid_mem_addr", 32'(MEM_ADDRESS), 32'd0);
    check("mid_mem_wdata", MEM_WRITEDATA, 32'd0);
    check("mid_d_rdata", D_READDATA, 32'd0);
    check("mid_i_rdata", I_READDATA, 32'd0);
    check("mid_d_busy", 32'(D_BUSYWAIT), 32'd1);
    D_READ = 1'b0;
    @(posedge CLK); #1 RESET = 1'b1;
    run_solo(1'b0, 1'b1, 1'b0, 6'h05, 32'h0, 3, mr, mw, lat, to);
    check("post_rst_timeout", 32'(to), 32'd0);
    check("post_rst_latency", 32'(lat), 32'd6);
    check("post_rst_d_rdata", D_READDATA, 32'hDEADBEEF);

    // Memory never signals busy: grant is held indefinitely.
    mem_hang = 1'b1;
    @(posedge CLK); #1;
    D_READ = 1'b1; D_ADDRESS = 6'h03;
    repeat (2) @(negedge CLK);
    cnt_a = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge CLK);
      if (!MEM_READ || !D_BUSYWAIT || dut.r_state != ST_GRANT) cnt_a++;
    end
    check("hang_held", 32'(cnt_a), 32'd0);
    do_reset();
    mem_hang = 1'b0;

    // Random traffic from both requesters.
    do_reset();
    mem_fixed_n = 0;
    last_owner = -1;
    fork
      proc_d();
      proc_i();
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports are named CLK and RESET. CLK is the rising-edge clock; RESET low clears all state immediately, independent of CLK.
REQ-002 Ports SHALL be, clock and reset first:
- CLK  in  1  system clock
- RESET  in  1  async active-low reset
- I_READ  in  1  instruction-cache block read request
- I_ADDRESS  in  6  instruction block address
- I_READDATA  out  32  instruction block returned
- I_BUSYWAIT  out  1  instruction requester stall
- D_READ  in  1  data-cache block read request
- D_WRITE  in  1  data-cache block write request
- D_ADDRESS  in  6  data block address
- D_WRITEDATA  in  32  data block to write
- D_READDATA  out  32  data block returned
- D_BUSYWAIT  out  1  data requester stall
- MEM_READ  out  1  main-memory read strobe
- MEM_WRITE  out  1  main-memory write strobe
- MEM_ADDRESS  out  6  main-memory block address
- MEM_WRITEDATA  out  32  main-memory write block
- MEM_READDATA  in  32  main-memory read block
- MEM_BUSYWAIT  in  1  main-memory busy

Function
REQ-003 The FSM SHALL have three states:
- IDLE: no owner.
- GRANT: memory access in flight for the owner.
- DONE: one-cycle completion.
REQ-004 In IDLE with any request sampled at a rising edge, the FSM SHALL move to GRANT on that edge and latch the owner, address and write data.
REQ-005 Owner selection when only one requester is active SHALL grant that requester.
REQ-006 Owner selection when both requesters are active SHALL be round-robin: grant the requester that did not own the last completed transaction; after reset, data wins first.
REQ-007 In GRANT, MEM_READ or MEM_WRITE SHALL be driven high from registers.
- MEM_ADDRESS and MEM_WRITEDATA SHALL come from the latched values.
- Neither memory input may change while in GRANT.
REQ-008 If D_READ and D_WRITE are both high, the block SHALL treat the request as a write.
REQ-009 The block SHALL set a seen_busy flag on the first cycle in GRANT that MEM_BUSYWAIT is high.
REQ-010 Completion is the first rising edge in GRANT where seen_busy=1 and MEM_BUSYWAIT=0. On that edge the FSM SHALL:
- move to DONE;
- drop MEM_READ and MEM_WRITE;
- capture MEM_READDATA into the owner's readdata register, but only for a read.
REQ-011 DONE SHALL last exactly one cycle, then return to IDLE. A request pending in DONE is arbitrated in IDLE on the following edge.
REQ-012 X_BUSYWAIT SHALL be combinational: X_BUSYWAIT = (X request active) AND NOT (state==DONE AND owner==X). It is asserted in the same cycle the request rises.
REQ-013 A requester SHALL hold its request and address stable until it sees its busywait low. The non-owner SHALL stay stalled for the whole transaction.
REQ-014 I_READDATA and D_READDATA SHALL hold their last captured value until the next completed read for that requester.
REQ-015 Access latency SHALL be N+3 cycles from request-high to busywait-low, where N is the memory busy duration in cycles.
REQ-016 The round-robin pointer SHALL update only on the DONE→IDLE transition.

Reset
REQ-017 Assertion of RESET, including mid-transaction, SHALL set:
- state=IDLE and seen_busy=0;
- MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0;
- I_READDATA=0, D_READDATA=0;
- pointer=data-first.
Any in-flight transaction is abandoned without retry.
REQ-018 During reset, busywait outputs SHALL follow REQ-012 with state=IDLE, so an active request reads as stalled.

Structure
REQ-019 A shared package SHALL hold:
- the state encoding (IDLE, GRANT, DONE);
- owner IDs (OWN_I=0, OWN_D=1);
- ADDR_W=6 and BLOCK_W=32.
REQ-020 The block SHALL be a single module with no sub-modules; the round-robin choice is a two-input expression inside the FSM.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- D_READ only, addr 0x05, memory busy 5 cycles returning 0xDEADBEEF -> MEM_READ for 6 cycles, D_READDATA=0xDEADBEEF, D_BUSYWAIT low exactly 8 cycles after request.
- I_READ and D_WRITE (addr 0x0A, data 0x12345678) rising in the same cycle right after reset -> data granted first, I_BUSYWAIT stays high, then instruction granted.
- Both requesters continuously active for 4 transactions -> grants alternate D, I, D, I.
- D_READ and D_WRITE both high -> MEM_WRITE=1, MEM_READ=0, D_READDATA unchanged.
- RESET pulsed low mid-GRANT -> MEM_READ=0 asynchronously, state IDLE, outputs zero, fresh request served normally after release.
- MEM_BUSYWAIT never rises -> block stays in GRANT and requester busywait stays high.
